// File: rtl/cond_logic.sv
// cond_logic: ARM condition evaluation, NZCV flags register and write gating.
// Optional exec/squash statistics counters when COND_STATS_EN is defined.
module cond_logic #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
`ifdef COND_STATS_EN
  , parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [3:0]            cond,
  input  logic [3:0]            alu_flags,
  input  logic [1:0]            flag_w,
  input  logic                  no_write,
  input  logic                  pcs,
  input  logic                  reg_w,
  input  logic                  mem_w,
  output logic                  cond_ex,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic                  mem_write,
`ifdef COND_STATS_EN
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] exec_count,
  output logic [STAT_WIDTH-1:0] squash_count,
`endif
  output logic [3:0]            flags
);
  logic n, z, c, v, pass;
  logic [15:0] tbl;
  assign {n, z, c, v} = flags;
  // Indexed lookup so an unknown cond propagates X in simulation
  assign tbl = {1'b0, 1'b1, z | (n != v), ~z & (n == v), n != v, n == v, ~c | z, c & ~z,
                ~v, v, ~n, n, ~c, c, ~z, z};
  assign cond_ex = tbl[cond];
  assign pass = en & cond_ex;
  assign pc_src = pass & pcs;
  assign reg_write = pass & reg_w & ~no_write;
  assign mem_write = pass & mem_w;
  always_ff @(posedge clk or posedge reset)
    if (reset) flags <= FLAGS_RESET;
    else begin
      if (pass & flag_w[1]) flags[3:2] <= alu_flags[3:2];
      if (pass & flag_w[0]) flags[1:0] <= alu_flags[1:0];
    end
`ifdef COND_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      exec_count <= '0;
      squash_count <= '0;
    end else if (stat_clr) begin
      exec_count <= '0;
      squash_count <= '0;
    end else if (en) begin
      if (cond_ex && !(&exec_count)) exec_count <= exec_count + 1'b1;
      if (!cond_ex && !(&squash_count)) squash_count <= squash_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed plus randomized checks of cond_logic against an abstract ARM condition model.
module tb_cond_logic;
  logic clk = 0, reset, en, no_write, pcs, reg_w, mem_w;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_w;
  logic cond_ex, pc_src, reg_write, mem_write;
  logic [3:0] flags;
  int checks = 0, errors = 0;
  logic [3:0] mf;
`ifdef COND_STATS_EN
  localparam int SW = 4;
  logic stat_clr;
  logic [SW-1:0] exec_count, squash_count;
  int ec = 0, sc = 0;
`endif

  cond_logic #(
    .FLAGS_RESET(4'b0000)
`ifdef COND_STATS_EN
    , .STAT_WIDTH(SW)
`endif
  ) dut (
    .clk(clk), .reset(reset), .en(en), .cond(cond), .alu_flags(alu_flags),
    .flag_w(flag_w), .no_write(no_write), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
    .cond_ex(cond_ex), .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
`ifdef COND_STATS_EN
    .stat_clr(stat_clr), .exec_count(exec_count), .squash_count(squash_count),
`endif
    .flags(flags)
  );

  always #5 clk = ~clk;

  // ARM definition: even codes test a base predicate, odd codes invert it; 1111 never
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic nn, zz, cy, ov, base;
    {nn, zz, cy, ov} = f;
    case (cc[3:1])
      3'd0: base = zz;
      3'd1: base = cy;
      3'd2: base = nn;
      3'd3: base = ov;
      3'd4: base = cy && !zz;
      3'd5: base = nn == ov;
      3'd6: base = !zz && nn == ov;
      default: base = 1'b1;
    endcase
    return (cc == 4'hF) ? 1'b0 : (base ^ cc[0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, check combinational gating, clock it, check the model state
  task automatic apply(input logic [3:0] cc, input logic [3:0] af, input logic [1:0] fw,
                       input logic nw, input logic p, input logic rw, input logic mw, input logic e);
    logic ce;
    cond = cc; alu_flags = af; flag_w = fw; no_write = nw; pcs = p; reg_w = rw; mem_w = mw; en = e;
    #1;
    ce = ref_cond(cc, mf);
    chk("cond_ex", cond_ex, ce);
    chk("pc_src", pc_src, e && p && ce);
    chk("reg_write", reg_write, e && rw && ce && !nw);
    chk("mem_write", mem_write, e && mw && ce);
    @(posedge clk);
    if (e && ce && fw[1]) mf[3:2] = af[3:2];
    if (e && ce && fw[0]) mf[1:0] = af[1:0];
`ifdef COND_STATS_EN
    if (stat_clr) begin ec = 0; sc = 0; end
    else if (e) begin
      if (ce) ec = (ec < 2**SW - 1) ? ec + 1 : ec;
      else sc = (sc < 2**SW - 1) ? sc + 1 : sc;
    end
`endif
    @(negedge clk);
    chk("flags", flags, mf);
`ifdef COND_STATS_EN
    chk("exec_count", exec_count, ec);
    chk("squash_count", squash_count, sc);
`endif
  endtask

  initial begin
    reset = 1; en = 1; cond = 4'hE; alu_flags = 0; flag_w = 0; no_write = 0;
    pcs = 0; reg_w = 1; mem_w = 0; mf = 4'b0000;
`ifdef COND_STATS_EN
    stat_clr = 0;
`endif
    #2;
    chk("reset_flags", flags, 4'b0000);
    chk("reset_cond_ex_al", cond_ex, 1);
    chk("reset_reg_write", reg_write, 1);
    @(negedge clk);
    reset = 0;
    apply(4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 1);
    apply(4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 1);
    chk("eq_squash_reg_write", reg_write, 0);
    // compare-style op: no register write, flags become 0110
    apply(4'hE, 4'b0110, 2'b11, 1, 0, 1, 0, 1);
    chk("cmp_flags", flags, 4'b0110);
    for (int i = 0; i < 16; i++) apply(i[3:0], 4'hF, 2'b00, 0, 1, 1, 1, 1);
    // partial write from 0011: only N,Z update
    apply(4'hE, 4'b0011, 2'b11, 1, 0, 0, 0, 1);
    apply(4'hE, 4'b1000, 2'b10, 0, 0, 1, 0, 1);
    chk("partial_flags", flags, 4'b1011);
    apply(4'hA, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    chk("ge_pass", dut.cond_ex, 1);
    apply(4'hB, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    // squashed flag write from 0000
    apply(4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 1);
    apply(4'h0, 4'b1111, 2'b11, 0, 1, 1, 1, 1);
    chk("squash_flags", flags, 4'b0000);
    // bubble then async reset
    apply(4'hE, 4'b0100, 2'b10, 0, 0, 0, 0, 1);
    apply(4'hE, 4'b1111, 2'b11, 0, 1, 1, 1, 0);
    chk("bubble_flags", flags, 4'b0100);
    #2 reset = 1;
    #1 chk("async_reset_flags", flags, 4'b0000);
    mf = 4'b0000;
    cond = 4'hE; alu_flags = 4'hF; flag_w = 2'b11; en = 1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_edge_no_write", flags, 4'b0000);
    reset = 0;
`ifdef COND_STATS_EN
    ec = 0; sc = 0;
    for (int i = 0; i < 3; i++) apply(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) apply(4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    chk("stats_exec3", exec_count, 3);
    chk("stats_squash2", squash_count, 2);
    stat_clr = 1;
    apply(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    stat_clr = 0;
    chk("stats_clr", exec_count, 0);
    for (int i = 0; i < 20; i++) apply(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    chk("stats_sat", exec_count, 2**SW - 1);
`endif
    for (int i = 0; i < 300; i++)
      apply($urandom_range(15), $urandom_range(15), $urandom_range(3), $urandom_range(1),
            $urandom_range(1), $urandom_range(1), $urandom_range(1), ($urandom_range(3) != 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Consumer end of the ALU decoder's control interface: takes `flag_w` and `no_write` from the decoder, the ALU's NZCV result, and the instruction's condition field.
- Holds the architectural NZCV flags register and evaluates the ARM condition code against it.
- Squashes register write, memory write and PC writes for instructions whose condition fails.
- Sits between the main/ALU decoders and the datapath in the single-cycle core.

Parameters:
- FLAGS_RESET, 4'b0000, reset value of the NZCV flags register (bit3 = N, bit2 = Z, bit1 = C, bit0 = V).
- STAT_WIDTH, 16, width of the statistics counters (only used with COND_STATS_EN).

Ports:
- clk  input  1  core clock, all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  instruction valid/advance; 0 = bubble (no state change, all writes suppressed)
- cond  input  4  instruction condition field, Instr[31:28]
- alu_flags  input  4  ALU result flags {N,Z,C,V} of the current instruction
- flag_w  input  2  from ALU decoder: [1] = write N,Z; [0] = write C,V
- no_write  input  1  from ALU decoder: compare/test op, suppress register write
- pcs  input  1  instruction writes PC (branch or Rd = R15)
- reg_w  input  1  unconditional register-write request from main decoder
- mem_w  input  1  unconditional memory-write request from main decoder
- cond_ex  output  1  condition passed for current instruction
- pc_src  output  1  gated PC write
- reg_write  output  1  gated register write
- mem_write  output  1  gated memory write
- flags  output  4  current flags register {N,Z,C,V}

Behaviour:
- Reset (async, active-high): flags = FLAGS_RESET. All other outputs are combinational and follow from the reset flags.
- Reset applied mid-operation takes effect immediately; no flag write occurs on the edge coinciding with reset.
- `cond_ex` is combinational from `cond` and the registered flags. It never depends on `alu_flags`: a flag-setting instruction affects only later instructions.
- Condition table:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 0 (reserved, treated as never)
- Gated outputs (combinational, zero latency):
  - pc_src = en & pcs & cond_ex
  - reg_write = en & reg_w & cond_ex & ~no_write
  - mem_write = en & mem_w & cond_ex
- Flags register update at the rising clk edge:
  - N,Z <= alu_flags[3:2] when en & cond_ex & flag_w[1].
  - C,V <= alu_flags[1:0] when en & cond_ex & flag_w[0].
  - Each half is independent: logical ops with S=1 (flag_w = 10) leave C and V unchanged.
- A failed condition suppresses the flag write as well as the other writes, even with flag_w = 11.
- en = 0: flags hold; pc_src, reg_write and mem_write are 0; cond_ex still reflects the evaluation.
- flag_w = 00: flags hold regardless of alu_flags.
- Outputs carry no X when inputs are known. Unknown `cond` drives cond_ex to X in simulation only.

Optional Feature:
- Macro: COND_STATS_EN.
- Defined: adds input `stat_clr` (1), outputs `exec_count` and `squash_count` (STAT_WIDTH each).
  - On each edge with en = 1, exec_count increments if cond_ex = 1, otherwise squash_count increments.
  - Both counters saturate at all-ones (no wrap).
  - stat_clr = 1 zeroes both counters on that edge and takes priority over increment.
  - Reset zeroes both counters.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset, cond = 1110, reg_w = 1, en = 1 -> flags = 0000, cond_ex = 1, reg_write = 1. Then cond = 0000 (EQ) -> cond_ex = 0, reg_write = 0.
- CMP-style op, cond = 1110, flag_w = 11, no_write = 1, alu_flags = 0110, reg_w = 1 -> reg_write = 0 that cycle; after the edge flags = 0110. Then EQ -> cond_ex = 1, NE -> cond_ex = 0, CS -> cond_ex = 1, HI -> cond_ex = 0.
- Partial flag write: flags = 0011, apply flag_w = 10, alu_flags = 1000, AL -> flags = 1011 after the edge. Then GE -> cond_ex = 1, LT -> cond_ex = 0.
- Squashed flag write: flags = 0000, cond = 0000 (EQ fails), flag_w = 11, alu_flags = 1111, pcs = 1, mem_w = 1 -> pc_src = 0, mem_write = 0; flags remain 0000 after the edge.
- Bubble and async reset: en = 0 with flag_w = 11, alu_flags = 0100 -> flags hold, all gated writes 0. Then assert reset between edges with flags = 0100 -> flags = 0000 immediately, before the next clk edge.
- COND_STATS_EN: 3 passing + 2 failing instructions -> exec_count = 3, squash_count = 2. stat_clr -> both 0. Force exec_count to all-ones, then issue a passing instruction -> count holds at all-ones.
